// File: rtl/xbus_disk_ctrl.sv
// CADR xbus disk controller: register slave at DECODE_BASE plus DMA master running CCW lists.
// Optional build macro XBUS_DISK_NXM_CHECK_EN aborts on a granted but undecoded master cycle.
module xbus_disk_ctrl #(
  parameter logic [21:0] DECODE_BASE = 22'o17377770,
  parameter int          BLOCK_WORDS = 256
) (
  input  logic        mclk,
  input  logic        reset,
  input  logic [21:0] addrin,
  output logic [21:0] addrout,
  input  logic [31:0] datain,
  output logic [31:0] dataout,
  input  logic        reqin,
  input  logic        writein,
  output logic        ackout,
  output logic        decodeout,
  output logic        reqout,
  output logic        writeout,
  input  logic        grantin,
  input  logic        decodein,
  output logic        interrupt,
  output logic        dsk_req,
  output logic        dsk_write,
  output logic [39:0] dsk_addr,
  output logic [31:0] dsk_wdata,
  input  logic [31:0] dsk_rdata,
  input  logic        dsk_ack
);
  localparam int IDX_W = $clog2(BLOCK_WORDS);
  localparam logic [3:0] OP_READ  = 4'o00;
  localparam logic [3:0] OP_WRITE = 4'o11;

  typedef enum logic [2:0] {
    IDLE, CCW_REQ, DSK_RD, MEM_WR, MEM_RD, DSK_WR, NEXT, DONE
  } state_t;

  state_t state, state_nxt;

  logic [3:0]        op;
  logic              ie, done, nxm, more;
  logic [21:0]       clp;
  logic [31:0]       da, word, rd_data;
  logic [21-IDX_W:0] page;
  logic [IDX_W-1:0]  idx;
  logic              idle, slv_wr, start, last_idx, xfer_ok, xfer_abort;

  // Master handshake: reqout holds with addrout/writeout/dataout stable until the
  // accepting cycle (grant, plus decode when checked); the FSM leaves the request
  // state on that edge, so reqout is low at least one cycle between requests.
`ifdef XBUS_DISK_NXM_CHECK_EN
  assign xfer_ok    = grantin & decodein;
  assign xfer_abort = grantin & ~decodein;
`else
  logic unused_decodein;
  assign unused_decodein = decodein;
  assign xfer_ok    = grantin;
  assign xfer_abort = 1'b0;
`endif

  assign decodeout = (addrin[21:3] == DECODE_BASE[21:3]);
  assign idle      = (state == IDLE);
  // One write per slave access, on the edge that raises ackout; ignored while busy.
  assign slv_wr    = reqin & decodeout & writein & ~ackout & idle;
  assign start     = slv_wr & (addrin[2:0] == 3'd3);
  assign last_idx  = &idx;

  assign addrout   = (state == MEM_WR || state == MEM_RD) ? {page, idx} : clp;
  assign dsk_addr  = {da, 8'(idx)};
  assign dsk_wdata = word;
  assign interrupt = done & ie;

  always_ff @(posedge mclk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    reqout    = 1'b0;
    writeout  = 1'b0;
    dsk_req   = 1'b0;
    dsk_write = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = (op == OP_READ || op == OP_WRITE) ? CCW_REQ : DONE;
      CCW_REQ: begin
        reqout = 1'b1;
        if (xfer_abort)   state_nxt = IDLE;
        else if (xfer_ok) state_nxt = (op == OP_READ) ? DSK_RD : MEM_RD;
      end
      DSK_RD: begin
        dsk_req = 1'b1;
        if (dsk_ack) state_nxt = MEM_WR;
      end
      MEM_WR: begin
        reqout   = 1'b1;
        writeout = 1'b1;
        if (xfer_abort)   state_nxt = IDLE;
        else if (xfer_ok) state_nxt = last_idx ? NEXT : DSK_RD;
      end
      MEM_RD: begin
        reqout = 1'b1;
        if (xfer_abort)   state_nxt = IDLE;
        else if (xfer_ok) state_nxt = DSK_WR;
      end
      DSK_WR: begin
        dsk_req   = 1'b1;
        dsk_write = 1'b1;
        if (dsk_ack) state_nxt = last_idx ? NEXT : MEM_RD;
      end
      NEXT:    state_nxt = more ? CCW_REQ : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      ackout <= 1'b0;
      op     <= '0;
      ie     <= 1'b0;
      done   <= 1'b0;
      nxm    <= 1'b0;
      more   <= 1'b0;
      clp    <= '0;
      da     <= '0;
      page   <= '0;
      idx    <= '0;
      word   <= '0;
    end else begin
      ackout <= reqin & decodeout;
      if (slv_wr) begin
        case (addrin[2:0])
          3'd0: begin
            op   <= datain[3:0];
            ie   <= datain[11];
            done <= 1'b0;
            nxm  <= 1'b0;
          end
          3'd1:    clp <= datain[21:0];
          3'd2:    da  <= datain;
          default: ;
        endcase
      end
      if (reqout && xfer_abort) begin
        nxm  <= 1'b1;
        done <= 1'b1;
      end
      case (state)
        CCW_REQ: if (xfer_ok) begin
          page <= datain[21:IDX_W];
          more <= datain[0];
          idx  <= '0;
        end
        DSK_RD:  if (dsk_ack) word <= dsk_rdata;
        MEM_WR:  if (xfer_ok) idx <= idx + IDX_W'(1);
        MEM_RD:  if (xfer_ok) word <= datain;
        DSK_WR:  if (dsk_ack) idx <= idx + IDX_W'(1);
        NEXT: begin
          da <= da + 32'd1;
          if (more) clp <= clp + 22'd1;
        end
        DONE:    done <= 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    case (addrin[2:0])
      3'd0:    rd_data = {20'd0, ie, 6'd0, nxm, done, 2'd0, idle};
      3'd1:    rd_data = {10'd0, addrout};
      3'd2:    rd_data = da;
      default: rd_data = '0;
    endcase
  end

  // The bus cycle belongs to the master while a memory write is requested.
  assign dataout = (reqout & writeout) ? word : rd_data;

endmodule

// File: tb/tb_xbus_disk_ctrl.sv
// Directed bench for xbus_disk_ctrl: register access, READ, chained WRITE, busy-ignore,
// odd ops, NXM handling (depends on XBUS_DISK_NXM_CHECK_EN) and reset mid-transfer.
module tb_xbus_disk_ctrl;
  localparam logic [21:0] BASE = 22'o17377770;

  logic        mclk, reset;
  logic [21:0] addrin, addrout;
  logic [31:0] datain, dataout, slv_data, mem_rdata;
  logic        reqin, writein, ackout, decodeout, reqout, writeout;
  logic        grantin, decodein, interrupt;
  logic        dsk_req, dsk_write, dsk_ack;
  logic [39:0] dsk_addr;
  logic [31:0] dsk_wdata, dsk_rdata;

  xbus_disk_ctrl dut (
    .mclk(mclk), .reset(reset), .addrin(addrin), .addrout(addrout),
    .datain(datain), .dataout(dataout), .reqin(reqin), .writein(writein),
    .ackout(ackout), .decodeout(decodeout), .reqout(reqout), .writeout(writeout),
    .grantin(grantin), .decodein(decodein), .interrupt(interrupt),
    .dsk_req(dsk_req), .dsk_write(dsk_write), .dsk_addr(dsk_addr),
    .dsk_wdata(dsk_wdata), .dsk_rdata(dsk_rdata), .dsk_ack(dsk_ack)
  );

  // clock / reset
  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  assign datain = grantin ? mem_rdata : slv_data;

  int checks = 0;
  int failures = 0;
  int ack_lat;
  logic ack_drop;
  logic nxm_mode = 1'b0;

  // memory model: preloaded words are read-only; DUT writes land in wr_mem
  logic [31:0] init_mem [0:4095];
  logic [31:0] wr_mem   [0:4095];
  int gnt_wait = 0;
  int mem_grants = 0;
  int mem_writes = 0;

  always @(negedge mclk) begin
    grantin  = 1'b0;
    decodein = 1'b0;
    if (reqout) begin
      if (gnt_wait == 0) begin
        grantin  = 1'b1;
        decodein = !nxm_mode;
        mem_grants++;
        if (writeout) begin
          wr_mem[addrout[11:0]] = dataout;
          mem_writes++;
        end else begin
          mem_rdata = init_mem[addrout[11:0]];
        end
        gnt_wait = $urandom_range(0, 2);
      end else begin
        gnt_wait--;
      end
    end
  end

  // storage model: word i of any block reads as A000_0000+i
  logic [39:0] got_addr  [$];
  logic        got_wflag [$];
  logic [31:0] got_wdata [$];
  int dsk_wait = 0;

  always @(negedge mclk) begin
    dsk_ack = 1'b0;
    if (dsk_req) begin
      if (dsk_wait == 0) begin
        dsk_ack = 1'b1;
        got_addr.push_back(dsk_addr);
        got_wflag.push_back(dsk_write);
        if (dsk_write) got_wdata.push_back(dsk_wdata);
        else           dsk_rdata = 32'hA000_0000 + {24'd0, dsk_addr[7:0]};
        dsk_wait = $urandom_range(0, 3);
      end else begin
        dsk_wait--;
      end
    end
  end

  // scoreboard
  logic [31:0] exp_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic slv_access(input logic [2:0] r, input logic wr, input logic [31:0] d,
                            output logic [31:0] q);
    int n;
    @(negedge mclk);
    addrin   = BASE + {19'd0, r};
    reqin    = 1'b1;
    writein  = wr;
    slv_data = d;
    n = 0;
    do begin
      @(negedge mclk);
      n++;
    end while (ackout !== 1'b1 && n < 8);
    ack_lat = n;
    q = dataout;
    reqin   = 1'b0;
    writein = 1'b0;
    @(negedge mclk);
    ack_drop = ackout;
    addrin = '0;
  endtask

  task automatic slv_wr(input logic [2:0] r, input logic [31:0] d);
    logic [31:0] q;
    slv_access(r, 1'b1, d, q);
  endtask

  task automatic slv_rd(input logic [2:0] r, output logic [31:0] q);
    slv_access(r, 1'b0, 32'd0, q);
  endtask

  task automatic wait_irq(input int limit);
    int c;
    c = 0;
    while (interrupt !== 1'b1 && c < limit) begin
      @(negedge mclk);
      c++;
    end
  endtask

  initial begin
    logic [31:0] rd;
    int base_a, base_w, base_g, nw, bad;

    reset = 1'b1; reqin = 1'b0; writein = 1'b0; addrin = '0; slv_data = '0;
    repeat (3) @(negedge mclk);

    // reset state and address decode
    chk("rst_ackout", ackout, 1'b0);
    chk("rst_reqout", reqout, 1'b0);
    chk("rst_irq", interrupt, 1'b0);
    chk("rst_dsk_req", dsk_req, 1'b0);
    addrin = 22'o17377772; #1;
    chk("decode_in", decodeout, 1'b1);
    addrin = 22'o17377767; #1;
    chk("decode_out", decodeout, 1'b0);
    addrin = '0;
    @(negedge mclk);
    reset = 1'b0;
    slv_rd(3'd0, rd);
    chk("rst_status", rd, 32'h1);

    // register writes and ack timing
    slv_wr(3'd1, 32'o1000);
    chk("ack_latency", ack_lat, 1);
    chk("ack_drop", ack_drop, 1'b0);
    slv_wr(3'd2, 32'h1234_5678);
    slv_rd(3'd1, rd);
    chk("clp_rb", rd, 32'o1000);
    slv_rd(3'd2, rd);
    chk("da_rb", rd, 32'h1234_5678);
    slv_rd(3'd5, rd);
    chk("reg5_zero", rd, 32'h0);

    // single-CCW READ
    init_mem[12'o1000] = 32'o2000;
    base_a = got_addr.size();
    base_w = mem_writes;
    slv_wr(3'd0, 32'h0000_0800);
    slv_wr(3'd3, 32'h0);
    wait_irq(5000);
    chk("read_irq", interrupt, 1'b1);
    chk("read_dsk_count", got_addr.size() - base_a, 256);
    chk("read_mem_count", mem_writes - base_w, 256);
    bad = 0;
    for (int i = base_a; i < got_addr.size(); i++) if (got_wflag[i] !== 1'b0) bad++;
    chk("read_dsk_write_low", bad, 0);
    chk("read_first_daddr", got_addr[base_a], {32'h1234_5678, 8'h00});
    for (int i = 0; i < 256; i++)
      chk("read_mem_word", wr_mem[12'o2000 + i], 32'hA000_0000 + i);
    slv_rd(3'd2, rd);
    chk("read_da", rd, 32'h1234_5679);
    slv_rd(3'd0, rd);
    chk("read_status", rd, 32'h809);

    // COMMAND write clears done and the interrupt
    slv_wr(3'd0, 32'h0000_0809);
    chk("irq_cleared", interrupt, 1'b0);
    slv_rd(3'd0, rd);
    chk("status_cleared", rd, 32'h801);

    // chained WRITE, DA wraps, busy writes ignored
    init_mem[12'o1010] = 32'o3000 | 32'h1;
    init_mem[12'o1011] = 32'o4000;
    for (int i = 0; i < 256; i++) begin
      init_mem[12'o3000 + i] = 32'h5000_0000 + i * 7;
      exp_q.push_back(32'h5000_0000 + i * 7);
    end
    for (int i = 0; i < 256; i++) begin
      init_mem[12'o4000 + i] = 32'hC000_0000 | (i << 4);
      exp_q.push_back(32'hC000_0000 | (i << 4));
    end
    slv_wr(3'd1, 32'o1010);
    slv_wr(3'd2, 32'hFFFF_FFFF);
    base_a = got_addr.size();
    base_w = got_wdata.size();
    slv_wr(3'd3, 32'h0);
    repeat (40) @(negedge mclk);
    slv_wr(3'd2, 32'hDEAD_BEEF);
    slv_wr(3'd3, 32'h0);
    slv_wr(3'd0, 32'h0);
    wait_irq(8000);
    chk("write_irq", interrupt, 1'b1);
    nw = got_wdata.size() - base_w;
    chk("write_word_count", nw, 512);
    bad = 0;
    for (int i = base_a; i < got_addr.size(); i++) if (got_wflag[i] !== 1'b1) bad++;
    chk("write_dsk_write_high", bad, 0);
    for (int i = 0; i < nw && i < exp_q.size(); i++)
      chk("write_word", got_wdata[base_w + i], exp_q[i]);
    if (got_addr.size() - base_a >= 512) begin
      chk("write_daddr_first", got_addr[base_a], {32'hFFFF_FFFF, 8'h00});
      chk("write_daddr_255", got_addr[base_a + 255], {32'hFFFF_FFFF, 8'hFF});
      chk("write_daddr_256", got_addr[base_a + 256], {32'h0000_0000, 8'h00});
    end
    slv_rd(3'd1, rd);
    chk("write_clp", rd, 32'o1011);
    slv_rd(3'd2, rd);
    chk("write_da", rd, 32'h1);
    slv_rd(3'd0, rd);
    chk("write_status", rd, 32'h809);
    base_a = got_addr.size();
    repeat (30) @(negedge mclk);
    chk("no_restart_dsk", got_addr.size() - base_a, 0);
    chk("no_restart_req", reqout, 1'b0);

    // unknown op completes with no traffic
    base_a = got_addr.size();
    base_g = mem_grants;
    slv_wr(3'd0, 32'h0000_0805);
    slv_wr(3'd3, 32'h0);
    wait_irq(10);
    chk("odd_irq", interrupt, 1'b1);
    chk("odd_mem_traffic", mem_grants - base_g, 0);
    chk("odd_dsk_traffic", got_addr.size() - base_a, 0);
    slv_rd(3'd0, rd);
    chk("odd_status", rd, 32'h809);

    // granted but undecoded master cycle
    nxm_mode = 1'b1;
    base_a = got_addr.size();
    slv_wr(3'd0, 32'h0000_0800);
    slv_wr(3'd3, 32'h0);
`ifdef XBUS_DISK_NXM_CHECK_EN
    wait_irq(20);
    chk("nxm_irq", interrupt, 1'b1);
    chk("nxm_no_dsk", got_addr.size() - base_a, 0);
    chk("nxm_reqout", reqout, 1'b0);
    slv_rd(3'd0, rd);
    chk("nxm_status", rd, 32'h819);
    nxm_mode = 1'b0;
    slv_wr(3'd0, 32'h0000_0800);
    slv_rd(3'd0, rd);
    chk("nxm_cleared", rd, 32'h801);
`else
    wait_irq(5000);
    chk("nodec_irq", interrupt, 1'b1);
    chk("nodec_dsk_count", got_addr.size() - base_a, 256);
    chk("nodec_mem_word", wr_mem[12'o4000 + 5], 32'hA000_0005);
    slv_rd(3'd0, rd);
    chk("nodec_status", rd, 32'h809);
    nxm_mode = 1'b0;
`endif

    // reset in the middle of a READ
    slv_wr(3'd0, 32'h0000_0800);
    slv_wr(3'd3, 32'h0);
    repeat (40) @(negedge mclk);
    reset = 1'b1;
    @(negedge mclk);
    chk("midrst_reqout", reqout, 1'b0);
    chk("midrst_dsk_req", dsk_req, 1'b0);
    chk("midrst_irq", interrupt, 1'b0);
    reset = 1'b0;
    slv_rd(3'd0, rd);
    chk("midrst_status", rd, 32'h1);
    slv_rd(3'd1, rd);
    chk("midrst_clp", rd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
